// File: rtl/alu_decoder_regfile_if.sv
// ---------------------------------------------------------------------------
// alu_decoder_regfile_if
//   Instruction-execute bus for alu_decoder_regfile.
//   master : drives the instruction, its PC and the commit enable
//   slave  : returns next PC, writeback value, raw ALU result, illegal flag
//
//   i_insn        32  instruction word to decode and execute
//   i_pc          32  address of i_insn
//   i_valid        1  commit enable (register write only when high)
//   o_next_pc     32  next PC for this instruction
//   o_rd_wdata    32  writeback value for rd
//   o_alu_result  32  raw ALU result
//   o_illegal      1  instruction not supported
// ---------------------------------------------------------------------------
interface alu_decoder_regfile_if;
  logic [31:0] i_insn;
  logic [31:0] i_pc;
  logic        i_valid;
  logic [31:0] o_next_pc;
  logic [31:0] o_rd_wdata;
  logic [31:0] o_alu_result;
  logic        o_illegal;

  modport master (
    output i_insn, i_pc, i_valid,
    input  o_next_pc, o_rd_wdata, o_alu_result, o_illegal
  );

  modport slave (
    input  i_insn, i_pc, i_valid,
    output o_next_pc, o_rd_wdata, o_alu_result, o_illegal
  );
endinterface

// File: rtl/alu_decoder_regfile.sv
// ---------------------------------------------------------------------------
// alu_decoder_regfile
//   Single-cycle RV32I integer datapath: decode, register read, ALU and
//   next-PC are purely combinational from the instruction, its PC and the
//   register file. The register file commits on the rising clock edge.
//
//   Ports
//     i_clk    1   clock, state updates on rising edge
//     i_reset  1   asynchronous active-high reset, clears x1..x31
//     bus          alu_decoder_regfile_if.slave (instruction in, results out)
//
//   Configuration
//     RV32E_EN  defined   : only x0..x15 implemented; any rd/rs1/rs2 field
//                           >= 16 in a register-using instruction is illegal
//               undefined : full 32-entry register file
//
//   Supported: LUI, AUIPC, JAL, JALR, BRANCH, OP-IMM, OP. Everything else
//   (LOAD/STORE/FENCE/SYSTEM, reserved encodings) raises o_illegal.
// ---------------------------------------------------------------------------
module alu_decoder_regfile (
  input logic                  i_clk,
  input logic                  i_reset,
  alu_decoder_regfile_if.slave bus
);

`ifdef RV32E_EN
  localparam int unsigned NREGS = 16;
`else
  localparam int unsigned NREGS = 32;
`endif
  localparam int unsigned IDXW = $clog2(NREGS);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  // Encoding is {funct7[5], funct3} so OP/OP-IMM fields map directly.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_op_e;

  // -------------------------------------------------------------------------
  // Instruction fields and immediates
  // -------------------------------------------------------------------------
  logic [31:0] insn;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm_i;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign insn   = bus.i_insn;
  assign pc     = bus.i_pc;
  assign opcode = insn[6:0];
  assign rd     = insn[11:7];
  assign funct3 = insn[14:12];
  assign rs1    = insn[19:15];
  assign rs2    = insn[24:20];
  assign funct7 = insn[31:25];

  assign imm_i = {{20{insn[31]}}, insn[31:20]};
  assign imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
  assign imm_u = {insn[31:12], 12'b0};
  assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

  // -------------------------------------------------------------------------
  // Register file: x0 is not stored; reads of index 0 return zero.
  // -------------------------------------------------------------------------
  logic [31:0]     regs [1:NREGS-1];
  logic [IDXW-1:0] rs1_idx;
  logic [IDXW-1:0] rs2_idx;
  logic [IDXW-1:0] rd_idx;
  logic [31:0]     rs1_data;
  logic [31:0]     rs2_data;

  assign rs1_idx = rs1[IDXW-1:0];
  assign rs2_idx = rs2[IDXW-1:0];
  assign rd_idx  = rd[IDXW-1:0];

  assign rs1_data = (rs1_idx == '0) ? '0 : regs[rs1_idx];
  assign rs2_data = (rs2_idx == '0) ? '0 : regs[rs2_idx];

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  logic        dec_illegal;
  logic        reg_illegal;
  logic        illegal;
  logic        writes_rd;
  logic        is_jal;
  logic        is_jalr;
  logic        is_branch;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  alu_op_e     alu_op;

  always_comb begin
    dec_illegal = 1'b0;
    writes_rd   = 1'b0;
    is_jal      = 1'b0;
    is_jalr     = 1'b0;
    is_branch   = 1'b0;
    alu_a       = rs1_data;
    alu_b       = rs2_data;
    alu_op      = ALU_ADD;

    if (insn[1:0] != 2'b11) dec_illegal = 1'b1;

    case (opcode)
      OPC_LUI: begin
        writes_rd = 1'b1;
        alu_a     = '0;
        alu_b     = imm_u;
      end
      OPC_AUIPC: begin
        writes_rd = 1'b1;
        alu_a     = pc;
        alu_b     = imm_u;
      end
      OPC_JAL: begin
        // ALU forms the jump target pc + J-imm.
        writes_rd = 1'b1;
        is_jal    = 1'b1;
        alu_a     = pc;
        alu_b     = imm_j;
      end
      OPC_JALR: begin
        writes_rd = 1'b1;
        is_jalr   = 1'b1;
        alu_b     = imm_i;
        if (funct3 != 3'b000) dec_illegal = 1'b1;
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        alu_op    = ALU_SUB;
        if (funct3[2:1] == 2'b01) dec_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        writes_rd = 1'b1;
        alu_b     = imm_i;
        // funct7[5] only selects SRAI; elsewhere those bits are immediate.
        alu_op    = alu_op_e'({(funct3 == 3'b101) ? insn[30] : 1'b0, funct3});
        if (funct3 == 3'b001 && funct7 != 7'b0000000) dec_illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
          dec_illegal = 1'b1;
      end
      OPC_OP: begin
        writes_rd = 1'b1;
        alu_op    = alu_op_e'({insn[30], funct3});
        if (!(funct7 == 7'b0000000 ||
              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
          dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

`ifdef RV32E_EN
  logic uses_rs1;
  logic uses_rs2;

  always_comb begin
    uses_rs1    = (opcode == OPC_JALR) || (opcode == OPC_BRANCH) ||
                  (opcode == OPC_OP_IMM) || (opcode == OPC_OP);
    uses_rs2    = (opcode == OPC_BRANCH) || (opcode == OPC_OP);
    reg_illegal = (writes_rd && rd[4]) || (uses_rs1 && rs1[4]) ||
                  (uses_rs2 && rs2[4]);
  end
`else
  assign reg_illegal = 1'b0;
`endif

  assign illegal = dec_illegal | reg_illegal;

  // -------------------------------------------------------------------------
  // ALU
  // -------------------------------------------------------------------------
  logic [31:0] alu_y;
  logic [4:0]  shamt;

  assign shamt = alu_b[4:0];

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD:  alu_y = alu_a + alu_b;
      ALU_SUB:  alu_y = alu_a - alu_b;
      ALU_SLL:  alu_y = alu_a << shamt;
      ALU_SLT:  alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'b0, alu_a < alu_b};
      ALU_XOR:  alu_y = alu_a ^ alu_b;
      ALU_SRL:  alu_y = alu_a >> shamt;
      ALU_SRA:  alu_y = $unsigned($signed(alu_a) >>> shamt);
      ALU_OR:   alu_y = alu_a | alu_b;
      ALU_AND:  alu_y = alu_a & alu_b;
      default:  alu_y = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Branch resolution and next PC
  // -------------------------------------------------------------------------
  logic        taken;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (rs1_data == rs2_data);
      3'b001:  taken = (rs1_data != rs2_data);
      3'b100:  taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  taken = (rs1_data <  rs2_data);
      3'b111:  taken = (rs1_data >= rs2_data);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = pc_plus4;
    if (!illegal) begin
      if (is_jal)
        next_pc = alu_y;
      else if (is_jalr)
        next_pc = {alu_y[31:1], 1'b0};
      else if (is_branch && taken)
        next_pc = pc + imm_b;
    end
  end

  // -------------------------------------------------------------------------
  // Writeback
  // -------------------------------------------------------------------------
  logic [31:0] rd_wdata;
  logic        we;

  assign rd_wdata = (is_jal || is_jalr) ? pc_plus4 : alu_y;
  assign we       = bus.i_valid && !illegal && writes_rd && (rd_idx != '0);

  // Reset dominates the clock, so an edge seen while i_reset is high
  // never commits a write.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[rd_idx] <= rd_wdata;
    end
  end

  assign bus.o_next_pc    = next_pc;
  assign bus.o_rd_wdata   = rd_wdata;
  assign bus.o_alu_result = alu_y;
  assign bus.o_illegal    = illegal;

endmodule

// File: tb/tb_alu_decoder_regfile.sv
// ---------------------------------------------------------------------------
// tb_alu_decoder_regfile
//   Scoreboard bench: each stimulus pushes its expected outputs, the bench
//   drives the instruction at the falling edge and pops/compares one time
//   unit later; the register write commits at the following rising edge.
//   Register contents are observed through ADDI x0,xN,0 with i_valid=0.
// ---------------------------------------------------------------------------
module tb_alu_decoder_regfile;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam int unsigned SEL_NPC = 0;
  localparam int unsigned SEL_WD  = 1;
  localparam int unsigned SEL_ALU = 2;
  localparam int unsigned SEL_ILL = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_decoder_regfile_if bus ();

  alu_decoder_regfile dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m [0:31];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int unsigned sel,
                      input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.sel = sel;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_NPC: got = bus.o_next_pc;
        SEL_WD:  got = bus.o_rd_wdata;
        SEL_ALU: got = bus.o_alu_result;
        default: got = {31'b0, bus.o_illegal};
      endcase
      check_val(e.tag, got, e.exp);
    end
  endtask

  task automatic drive(input logic [31:0] insn, input logic [31:0] pc,
                       input logic v);
    @(negedge clk);
    bus.i_insn  = insn;
    bus.i_pc    = pc;
    bus.i_valid = v;
    #1;
    drain();
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd,
      input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7,
      input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3,
      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm,
      input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] model_alu(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1101: return $unsigned($signed(a) >>> b[4:0]);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk_reg(input string tag, input logic [4:0] n,
                         input logic [31:0] e);
    push(tag, SEL_ALU, e);
    drive(enc_i(12'h000, n, 3'b000, 5'd0, OPC_OP_IMM), 32'h0, 1'b0);
  endtask

  task automatic addi(input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [11:0] imm);
    drive(enc_i(imm, rs1, 3'b000, rd, OPC_OP_IMM), 32'h0, 1'b1);
  endtask

  // LUI+ADDI pair; upper part pre-rounded for the sign-extended low 12 bits.
  task automatic set_reg(input logic [4:0] n, input logic [31:0] v);
    logic [31:0] hi;
    hi = (v + 32'h800) >> 12;
    drive({hi[19:0], n, OPC_LUI}, 32'h0, 1'b1);
    push("set_reg", SEL_ALU, v);
    drive(enc_i(v[11:0], n, 3'b000, n, OPC_OP_IMM), 32'h0, 1'b1);
    m[n] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  ops [10];
    logic [3:0]  op;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rdx;
    logic [31:0] e;

    ops = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7};
    for (int i = 0; i < 32; i++) m[i] = 32'h0;

    rst         = 1'b1;
    bus.i_insn  = 32'h0;
    bus.i_pc    = 32'h0;
    bus.i_valid = 1'b0;

    // Reset state
    chk_reg("reset_x1", 5'd1, 32'h0);
    push("reset_ill", SEL_ILL, 32'd0);
    chk_reg("reset_x31", 5'd31, 32'h0);
    rst = 1'b0;

    // ADDI x1,x0,5 at 0x80000000
    push("addi_npc", SEL_NPC, 32'h80000004);
    push("addi_wd",  SEL_WD,  32'd5);
    push("addi_ill", SEL_ILL, 32'd0);
    drive(32'h00500093, 32'h80000000, 1'b1);
    chk_reg("addi_x1", 5'd1, 32'd5);

    // SUB / SLTU
    addi(5'd2, 5'd0, 12'd7);
    push("sub_alu", SEL_ALU, 32'hFFFFFFFE);
    drive(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, 1'b1);
    chk_reg("sub_x3", 5'd3, 32'hFFFFFFFE);
    push("sltu_alu", SEL_ALU, 32'd1);
    drive(enc_r(7'b0000000, 5'd2, 5'd1, 3'b011, 5'd4), 32'h0, 1'b1);
    chk_reg("sltu_x4", 5'd4, 32'd1);

    // JAL x1,+8
    push("jal_wd",  SEL_WD,  32'h80000004);
    push("jal_npc", SEL_NPC, 32'h80000008);
    drive(32'h008000EF, 32'h80000000, 1'b1);
    chk_reg("jal_x1", 5'd1, 32'h80000004);

    // Branches; BEQ +16 has rd field = 16, which must stay 0
    addi(5'd1, 5'd0, 12'd3);
    addi(5'd2, 5'd0, 12'd3);
    push("beq_npc", SEL_NPC, 32'h00000110);
    drive(enc_b(13'd16, 5'd2, 5'd1, 3'b000), 32'h100, 1'b1);
`ifndef RV32E_EN
    chk_reg("beq_nowrite_x16", 5'd16, 32'h0);
`endif
    push("bne_npc", SEL_NPC, 32'h00000104);
    drive(enc_b(13'd16, 5'd2, 5'd1, 3'b001), 32'h100, 1'b1);
    addi(5'd5, 5'd0, 12'hFFF);
    push("blt_npc", SEL_NPC, 32'h000001F8);
    drive(enc_b(13'h1FF8, 5'd1, 5'd5, 3'b100), 32'h200, 1'b1);
    push("bltu_npc", SEL_NPC, 32'h00000204);
    drive(enc_b(13'h1FF8, 5'd1, 5'd5, 3'b110), 32'h200, 1'b1);
    push("bgeu_npc", SEL_NPC, 32'h00000220);
    drive(enc_b(13'd32, 5'd1, 5'd5, 3'b111), 32'h200, 1'b1);

    // JALR x6,x1,6 -> target (3+6)&~1
    push("jalr_npc", SEL_NPC, 32'h00000008);
    push("jalr_wd",  SEL_WD,  32'h00000304);
    drive(enc_i(12'd6, 5'd1, 3'b000, 5'd6, OPC_JALR), 32'h300, 1'b1);
    chk_reg("jalr_x6", 5'd6, 32'h00000304);

    // LUI / AUIPC
    push("lui_alu", SEL_ALU, 32'h12345000);
    drive({20'h12345, 5'd7, OPC_LUI}, 32'h0, 1'b1);
    push("auipc_alu", SEL_ALU, 32'h00002000);
    drive({20'h00001, 5'd8, OPC_AUIPC}, 32'h1000, 1'b1);
    chk_reg("auipc_x8", 5'd8, 32'h00002000);

    // Shift immediates
    drive({20'h80000, 5'd10, OPC_LUI}, 32'h0, 1'b1);
    push("srai_alu", SEL_ALU, 32'hF8000000);
    drive(enc_i({7'b0100000, 5'd4}, 5'd10, 3'b101, 5'd11, OPC_OP_IMM), 32'h0, 1'b1);
    push("srli_alu", SEL_ALU, 32'h08000000);
    drive(enc_i({7'b0000000, 5'd4}, 5'd10, 3'b101, 5'd12, OPC_OP_IMM), 32'h0, 1'b1);

    // Illegal encodings: no register changes, pc+4
    push("zero_ill", SEL_ILL, 32'd1);
    push("zero_npc", SEL_NPC, 32'h00000404);
    drive(32'h00000000, 32'h400, 1'b1);
    push("mul_ill", SEL_ILL, 32'd1);
    drive(enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, 1'b1);
    push("load_ill", SEL_ILL, 32'd1);
    drive(32'h0000A083, 32'h0, 1'b1);
    push("jalr_f3_ill", SEL_ILL, 32'd1);
    push("jalr_f3_npc", SEL_NPC, 32'h00000504);
    drive(enc_i(12'd6, 5'd1, 3'b001, 5'd6, OPC_JALR), 32'h500, 1'b1);
    push("ill_noval", SEL_ILL, 32'd1);
    drive(32'h00000000, 32'h0, 1'b0);
    chk_reg("ill_x1", 5'd1, 32'd3);
    chk_reg("ill_x3", 5'd3, 32'hFFFFFFFE);
    push("x0_alu", SEL_ALU, 32'd9);
    addi(5'd0, 5'd0, 12'd9);
    chk_reg("x0_zero", 5'd0, 32'h0);

    // Reset between edges clears immediately and blocks the write
    addi(5'd1, 5'd0, 12'd5);
    chk_reg("pre_rst_x1", 5'd1, 32'd5);
    rst = 1'b1;
    #1;
    push("async_rst_x1", SEL_ALU, 32'h0);
    drain();
    bus.i_insn  = enc_i(12'd9, 5'd0, 3'b000, 5'd1, OPC_OP_IMM);
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reg("rst_nowrite_x1", 5'd1, 32'h0);
    addi(5'd1, 5'd0, 12'd9);
    chk_reg("post_rst_x1", 5'd1, 32'd9);

`ifdef RV32E_EN
    push("e_rd16_ill", SEL_ILL, 32'd1);
    drive(enc_i(12'd1, 5'd0, 3'b000, 5'd16, OPC_OP_IMM), 32'h0, 1'b1);
`endif

    // Random register-register ops against the model
    for (int r = 1; r <= 7; r++) set_reg(5'(r), $urandom());
    for (int k = 0; k < 30; k++) begin
      op  = ops[$urandom_range(0, 9)];
      ra  = 5'($urandom_range(1, 7));
      rb  = 5'($urandom_range(1, 7));
      rdx = 5'($urandom_range(1, 7));
      e   = model_alu(op, m[ra], m[rb]);
      push("rand_alu", SEL_ALU, e);
      drive(enc_r(op[3] ? 7'b0100000 : 7'b0000000, rb, ra, op[2:0], rdx),
            32'h0, 1'b1);
      m[rdx] = e;
    end
    for (int r = 1; r <= 7; r++) chk_reg("rand_reg", 5'(r), m[r]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_decoder_regfile.md
ALU_DECODER_REGFILE -- requirements
Module: alu_decoder_regfile

Interface
REQ-001 Parameters: none; all widths fixed at 32-bit RV32I.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_reset  input  1  asynchronous, active-high reset.
REQ-004 i_insn  input  32  instruction word to decode and execute.
REQ-005 i_pc  input  32  address of i_insn.
REQ-006 i_valid  input  1  commit enable; register write occurs only when high.
REQ-007 o_next_pc  output  32  next PC for this instruction.
REQ-008 o_rd_wdata  output  32  writeback value for rd.
REQ-009 o_alu_result  output  32  raw ALU result.
REQ-010 o_illegal  output  1  instruction not supported.

Function
REQ-011 Decode, register read, ALU and next-PC SHALL be combinational from i_insn, i_pc and register state; zero-cycle latency.
REQ-012 Register file SHALL hold x1..x31 as 32-bit registers; x0 SHALL read 0 and ignore writes.
REQ-013 Two read ports (rs1=insn[19:15], rs2=insn[24:20]) and one write port (rd=insn[11:7]).
REQ-014 Write SHALL occur at rising i_clk when i_valid=1, o_illegal=0, rd!=0 and opcode writes rd (OP, OP-IMM, LUI, AUIPC, JAL, JALR); value = o_rd_wdata.
REQ-015 A read of the register being written in the same cycle SHALL return the old value; new value visible next cycle.
REQ-016 Immediates SHALL be sign-extended per RV32I I/S/B/U/J formats; ALU operand B = immediate for OP-IMM, LUI, AUIPC, JALR, else rs2 data.
REQ-017 ALU op (4 bits) = {funct7[5], funct3} for OP; for OP-IMM funct7[5] used only for funct3=101, else 0.
REQ-018 ALU ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; shift amount = B[4:0]; arithmetic modulo 2^32.
REQ-019 LUI: result = imm; AUIPC: result = i_pc + imm.
REQ-020 JAL: o_rd_wdata = i_pc+4, o_next_pc = i_pc + J-imm.
REQ-021 JALR: o_rd_wdata = i_pc+4, o_next_pc = (rs1 + I-imm) with bit0 cleared.
REQ-022 BRANCH (BEQ,BNE,BLT,BGE,BLTU,BGEU): taken -> o_next_pc = i_pc + B-imm, else i_pc+4; no register write.
REQ-023 All other legal instructions: o_next_pc = i_pc+4.
REQ-024 o_illegal=1 for any opcode not listed, reserved funct3/funct7 combinations, insn[1:0]!=11, and all LOAD/STORE/FENCE/SYSTEM; then o_next_pc = i_pc+4, no write.
REQ-025 o_illegal SHALL be independent of i_valid.

Reset
REQ-026 While i_reset=1, x1..x31 SHALL clear to 0 immediately, regardless of clock, and no write SHALL occur.
REQ-027 Reset asserted mid-operation SHALL discard any pending write; outputs reflect cleared registers combinationally.
REQ-028 First write after deassertion SHALL occur at the first rising edge with i_reset=0.

Configuration
REQ-029 Macro RV32E_EN defined: only x0..x15 implemented; any rd/rs1/rs2 field >=16 in a register-using instruction SHALL set o_illegal=1.
REQ-030 RV32E_EN undefined: full 32-register file, no register-index illegality.

Verification
REQ-031 Reset, then i_insn=0x00500093 (ADDI x1,x0,5), i_pc=0x80000000, i_valid=1, one edge -> x1=5, o_next_pc=0x80000004.
REQ-032 x1=5, x2=7, SUB x3,x1,x2 -> o_alu_result=0xFFFFFFFE, x3 written; SLTU x4,x1,x2 -> 1.
REQ-033 i_pc=0x80000000, i_insn=0x008000EF (JAL x1,+8) -> o_rd_wdata=0x80000004, o_next_pc=0x80000008.
REQ-034 x1=x2=3, BEQ x1,x2,+16 -> o_next_pc=i_pc+16, no write; BNE same operands -> i_pc+4.
REQ-035 i_insn=0x00000000 with i_valid=1 -> o_illegal=1, no register changes, o_next_pc=i_pc+4; ADDI x0,x0,9 -> x0 reads 0.
REQ-036 Assert i_reset between edges after x1=5 -> x1 reads 0 before next edge; with RV32E_EN, ADDI x16,x0,1 -> o_illegal=1.
